// File: rtl/quadrature_encoder_gen_pkg.sv
// Shared constants for the quadrature encoder emulator: Gray phase table,
// mode encodings and edge-timer state encodings.
package quadrature_encoder_gen_pkg;

  // {enc_a, enc_b} for position[1:0] = 0..3; forward order has A leading B.
  localparam logic [1:0] PH0 = 2'b00;
  localparam logic [1:0] PH1 = 2'b10;
  localparam logic [1:0] PH2 = 2'b11;
  localparam logic [1:0] PH3 = 2'b01;

  localparam logic MODE_VELOCITY = 1'b0;
  localparam logic MODE_POSITION = 1'b1;

  typedef enum logic [1:0] {
    StIdle,
    StCount,
    StEdge
  } tmr_state_e;

  function automatic logic [1:0] gray_phase(input logic [1:0] cnt);
    logic [1:0] ph;
    case (cnt)
      2'd0:    ph = PH0;
      2'd1:    ph = PH1;
      2'd2:    ph = PH2;
      default: ph = PH3;
    endcase
    return ph;
  endfunction

endpackage

// File: rtl/quadrature_encoder_gen_edge_timer.sv
// Programmable edge-interval down-counter: clamps the requested period, latches it
// on every reload and strobes expire in the cycle that enters the edge state.
module quadrature_encoder_gen_edge_timer
  import quadrature_encoder_gen_pkg::*;
#(
  parameter int unsigned MIN_EDGE_CYCLES = 4,
  parameter int unsigned PERIOD_WIDTH    = 24
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [PERIOD_WIDTH-1:0] period,
  input  logic                    run,
  input  logic                    rearm,
  output logic                    expire
);

  localparam logic [PERIOD_WIDTH-1:0] MinPeriod = PERIOD_WIDTH'(MIN_EDGE_CYCLES);

  tmr_state_e              state_q, state_d;
  logic [PERIOD_WIDTH-1:0] cnt_q, cnt_d;
  logic [PERIOD_WIDTH-1:0] p_eff;

  assign p_eff  = (period < MinPeriod) ? MinPeriod : period;
  assign expire = (state_q == StCount) && (cnt_q == '0) && run && !rearm;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (rearm || !run) begin
      state_d = run ? StCount : StIdle;
      cnt_d   = p_eff - PERIOD_WIDTH'(1);
    end else begin
      case (state_q)
        StIdle: begin
          state_d = StCount;
          cnt_d   = p_eff - PERIOD_WIDTH'(1);
        end
        StCount: begin
          if (cnt_q == '0) state_d = StEdge;
          else             cnt_d   = cnt_q - PERIOD_WIDTH'(1);
        end
        StEdge: begin
          // The edge cycle itself is one of the P cycles of the next interval.
          state_d = StCount;
          cnt_d   = p_eff - PERIOD_WIDTH'(2);
        end
        default: begin
          state_d = StIdle;
          cnt_d   = p_eff - PERIOD_WIDTH'(1);
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/quadrature_encoder_gen.sv
// Quadrature encoder emulator: registered A/B/index outputs driven from a position
// counter, stepped by the edge timer in velocity or move-to-target mode.
module quadrature_encoder_gen
  import quadrature_encoder_gen_pkg::*;
#(
  parameter int unsigned CLK_FREQ        = 16_000_000,
  parameter int unsigned MIN_EDGE_CYCLES = 4,
  parameter int unsigned PERIOD_WIDTH    = 24,
  parameter int unsigned CPR_LOG2        = 11
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    enable,
  input  logic                    mode,
  input  logic                    dir,
  input  logic [PERIOD_WIDTH-1:0] period,
  input  logic signed [31:0]      target_position,
  input  logic                    load,
  input  logic signed [31:0]      load_value,
  output logic                    enc_a,
  output logic                    enc_b,
  output logic                    enc_index,
  output logic signed [31:0]      position,
  output logic                    step,
  output logic                    at_target
);

  if (MIN_EDGE_CYCLES < 2 || CLK_FREQ == 0) begin : g_bad_params
    $error("quadrature_encoder_gen: MIN_EDGE_CYCLES must be >= 2, CLK_FREQ nonzero");
  end

  logic signed [31:0] position_q, position_d;
  logic [1:0]         ab_q;
  logic               index_q, step_q, at_target_q;
  logic signed [32:0] diff;
  logic               run, fwd, fire;

  // 33-bit difference so a move across the wrap point takes the long way.
  assign diff = {target_position[31], target_position} - {position_q[31], position_q};
  assign run  = enable && ((mode == MODE_VELOCITY) ? (period != '0) : (diff != '0));
  assign fwd  = (mode == MODE_VELOCITY) ? dir : !diff[32];

  quadrature_encoder_gen_edge_timer #(
    .MIN_EDGE_CYCLES(MIN_EDGE_CYCLES),
    .PERIOD_WIDTH   (PERIOD_WIDTH)
  ) u_edge_timer (
    .clk    (clk),
    .reset_n(reset_n),
    .period (period),
    .run    (run),
    .rearm  (load),
    .expire (fire)
  );

  always_comb begin
    position_d = position_q;
    if (load)      position_d = load_value;
    else if (fire) position_d = fwd ? position_q + 32'sd1 : position_q - 32'sd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      position_q  <= '0;
      ab_q        <= PH0;
      index_q     <= 1'b1;
      step_q      <= 1'b0;
      at_target_q <= 1'b0;
    end else begin
      position_q  <= position_d;
      ab_q        <= gray_phase(position_d[1:0]);
      index_q     <= (position_d[CPR_LOG2-1:0] == '0);
      step_q      <= fire;
      at_target_q <= (mode == MODE_POSITION) && (position_q == target_position);
    end
  end

  assign enc_a     = ab_q[1];
  assign enc_b     = ab_q[0];
  assign enc_index = index_q;
  assign position  = position_q;
  assign step      = step_q;
  assign at_target = at_target_q;

endmodule

// File: tb/tb_quadrature_encoder_gen.sv
// Directed plus randomized bench for quadrature_encoder_gen, checked against an
// edge-timing/position model and a behavioural quadrature decoder.
module tb_quadrature_encoder_gen;

  localparam int MinEdge = 4;

  logic               clk = 1'b0;
  logic               reset_n, enable, mode, dir, load;
  logic [23:0]        period;
  logic signed [31:0] target_position, load_value, position;
  logic               enc_a, enc_b, enc_index, step, at_target;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int last_step_cyc = 0;
  int dec_count = 0;
  int dec_adj = 0;
  logic signed [31:0] exp_pos = '0;
  logic [1:0] ab_tbl [4] = '{2'b00, 2'b10, 2'b11, 2'b01};
  logic [1:0] prev_ab = 2'b00;

  quadrature_encoder_gen #(
    .CLK_FREQ       (16_000_000),
    .MIN_EDGE_CYCLES(MinEdge),
    .PERIOD_WIDTH   (24),
    .CPR_LOG2       (11)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .enable         (enable),
    .mode           (mode),
    .dir            (dir),
    .period         (period),
    .target_position(target_position),
    .load           (load),
    .load_value     (load_value),
    .enc_a          (enc_a),
    .enc_b          (enc_b),
    .enc_index      (enc_index),
    .position       (position),
    .step           (step),
    .at_target      (at_target)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int idx_of(input logic [1:0] ab);
    for (int i = 0; i < 4; i++) if (ab_tbl[i] == ab) return i;
    return 0;
  endfunction

  function automatic int eff(input int p);
    return (p < MinEdge) ? MinEdge : p;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Behavioural decoder fed by A/B; a two-state jump is only legal while disabled (load).
  always @(negedge clk) begin
    int d;
    if (!reset_n) begin
      dec_count = 0;
    end else if ({enc_a, enc_b} != prev_ab) begin
      d = (idx_of({enc_a, enc_b}) - idx_of(prev_ab) + 4) % 4;
      if (d == 1)      dec_count++;
      else if (d == 3) dec_count--;
      else begin
        checks++;
        assert (enable === 1'b0) else begin
          errors++;
          $error("FAIL ab_jump: enable observed %b expected 0 for %b->%b", enable, prev_ab,
                 {enc_a, enc_b});
        end
      end
    end
    prev_ab = {enc_a, enc_b};
  end

  task automatic wait_edge(input int exp_int, input int dsign, input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < exp_int + 20; i++) begin
      @(negedge clk);
      if (step === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    chk({tag, "_seen"}, 32'(seen), 32'd1);
    if (seen) begin
      chk({tag, "_interval"}, 32'(cyc - last_step_cyc), 32'(exp_int));
      last_step_cyc = cyc;
      exp_pos = exp_pos + 32'(dsign);
      chk({tag, "_pos"}, position, exp_pos);
      chk({tag, "_ab"}, 32'({enc_a, enc_b}), 32'(ab_tbl[exp_pos[1:0]]));
      chk({tag, "_index"}, 32'(enc_index), 32'(exp_pos[10:0] == 11'd0));
    end
  endtask

  task automatic no_edge(input int n, input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (step !== 1'b0) seen = 1'b1;
    end
    chk({tag, "_nostep"}, 32'(seen), 32'd0);
    chk({tag, "_pos"}, position, exp_pos);
  endtask

  task automatic start_run(input int per, input bit d, input bit m);
    period = 24'(per);
    dir = d;
    mode = m;
    enable = 1'b1;
    last_step_cyc = cyc;
  endtask

  task automatic stop_run();
    enable = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic do_load(input logic signed [31:0] v);
    load = 1'b1;
    load_value = v;
    @(negedge clk);
    load = 1'b0;
    exp_pos = v;
    chk("load_pos", position, exp_pos);
    chk("load_ab", 32'({enc_a, enc_b}), 32'(ab_tbl[exp_pos[1:0]]));
    chk("load_index", 32'(enc_index), 32'(exp_pos[10:0] == 11'd0));
    chk("load_step", 32'(step), 32'd0);
    @(negedge clk);
    dec_adj = exp_pos - dec_count;
  endtask

  task automatic chk_decoder(input string tag);
    chk({tag, "_decoder"}, 32'(dec_count + dec_adj), exp_pos);
  endtask

  initial begin
    int per, n, delta, sgn, hi;
    bit d;
    reset_n = 1'b0; enable = 1'b0; mode = 1'b0; dir = 1'b1; period = '0;
    target_position = '0; load = 1'b0; load_value = '0;
    repeat (3) @(negedge clk);
    chk("rst_a", 32'(enc_a), 32'd0);
    chk("rst_b", 32'(enc_b), 32'd0);
    chk("rst_pos", position, 32'd0);
    chk("rst_step", 32'(step), 32'd0);
    chk("rst_at_target", 32'(at_target), 32'd0);
    chk("rst_index", 32'(enc_index), 32'd1);
    reset_n = 1'b1;
    @(negedge clk);

    // Velocity forward, period 10; first edge lands P cycles after leaving idle.
    start_run(10, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) wait_edge((i == 0) ? 11 : 10, 1, "vel10");
    chk("vel10_final", position, 32'd8);
    // Period change mid-interval only applies after the current interval.
    repeat (3) @(negedge clk);
    period = 24'd1;
    wait_edge(10, 1, "latch_old");
    wait_edge(4, 1, "clamp_a");
    wait_edge(4, 1, "clamp_b");
    period = 24'd0;
    no_edge(40, "period0");
    stop_run();
    chk_decoder("s1");

    // Reversal after three forward edges.
    do_load(32'sd0);
    start_run(5, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) wait_edge((i == 0) ? 6 : 5, 1, "fwd3");
    repeat (2) @(negedge clk);
    dir = 1'b0;
    wait_edge(5, -1, "rev_a");
    wait_edge(5, -1, "rev_b");
    stop_run();
    chk_decoder("rev");

    // Enable dropped mid-interval discards the timer; re-enable waits a full P.
    start_run(8, 1'b1, 1'b0);
    wait_edge(9, 1, "en_pre");
    repeat (3) @(negedge clk);
    enable = 1'b0;
    no_edge(6, "en_off");
    enable = 1'b1;
    last_step_cyc = cyc;
    wait_edge(9, 1, "en_resume");
    stop_run();

    // Position mode to -5.
    do_load(32'sd0);
    target_position = -32'sd5;
    start_run(6, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) wait_edge((i == 0) ? 7 : 6, -1, "pos_m5");
    chk("pos_at_target_lag", 32'(at_target), 32'd0);
    @(negedge clk);
    chk("pos_at_target", 32'(at_target), 32'd1);
    no_edge(30, "pos_hold");
    stop_run();
    chk_decoder("pos");

    // Randomized position moves.
    for (int it = 0; it < 4; it++) begin
      delta = int'($urandom_range(0, 8)) - 4;
      per = int'($urandom_range(0, 8));
      target_position = exp_pos + 32'(delta);
      start_run(per, 1'b0, 1'b1);
      if (delta == 0) begin
        no_edge(20, "rpos_zero");
      end else begin
        sgn = (delta > 0) ? 1 : -1;
        n = (delta > 0) ? delta : -delta;
        for (int k = 0; k < n; k++) wait_edge((k == 0) ? eff(per) + 1 : eff(per), sgn, "rpos");
        @(negedge clk);
        no_edge(eff(per) + 5, "rpos_hold");
      end
      chk("rpos_at_target", 32'(at_target), 32'd1);
      stop_run();
      chk_decoder("rpos");
    end

    // Randomized velocity runs.
    for (int it = 0; it < 5; it++) begin
      per = int'($urandom_range(0, 9));
      d = 1'($urandom_range(0, 1));
      n = int'($urandom_range(1, 4));
      start_run(per, d, 1'b0);
      if (per == 0) no_edge(25, "rvel_stop");
      else for (int k = 0; k < n; k++)
        wait_edge((k == 0) ? eff(per) + 1 : eff(per), d ? 1 : -1, "rvel");
      stop_run();
      chk_decoder("rvel");
    end

    // Index pulse across the revolution boundary.
    do_load(32'sd2047);
    start_run(4, 1'b1, 1'b0);
    wait_edge(5, 1, "idx_edge");
    hi = 0;
    repeat (3) begin
      @(negedge clk);
      if (enc_index === 1'b1) hi++;
    end
    chk("idx_width", 32'(hi), 32'd3);
    wait_edge(4, 1, "idx_after");

    // Load coincident with an edge wins: no step, timer re-armed.
    repeat (3) @(negedge clk);
    load = 1'b1;
    load_value = exp_pos;
    @(negedge clk);
    load = 1'b0;
    chk("ld_edge_step", 32'(step), 32'd0);
    chk("ld_edge_pos", position, exp_pos);
    last_step_cyc = cyc;
    wait_edge(4, 1, "ld_rearm");
    stop_run();
    chk_decoder("ld");

    // Wrap-around, then a position-mode move that takes the long way.
    do_load(32'sh7FFF_FFFF);
    start_run(4, 1'b1, 1'b0);
    wait_edge(5, 1, "wrap");
    chk("wrap_val", position, 32'h8000_0000);
    stop_run();
    target_position = 32'sh7FFF_FFFF;
    start_run(4, 1'b0, 1'b1);
    wait_edge(5, 1, "longway");

    // Asynchronous reset mid-interval.
    repeat (2) @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("arst_pos", position, 32'd0);
    chk("arst_ab", 32'({enc_a, enc_b}), 32'd0);
    chk("arst_index", 32'(enc_index), 32'd1);
    chk("arst_step", 32'(step), 32'd0);
    chk("arst_at_target", 32'(at_target), 32'd0);
    exp_pos = '0;
    no_edge(6, "arst_hold");
    enable = 1'b0;
    mode = 1'b0;
    target_position = '0;
    @(negedge clk);
    reset_n = 1'b1;
    dec_adj = 0;
    no_edge(6, "arst_release");
    chk_decoder("arst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
